password_attempt_ctrl: RTL

PASSWORD_ATTEMPT_CTRL -- requirements
Module: password_attempt_ctrl

---
 rtl/password_attempt_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/password_attempt_ctrl.sv
// Attempt limiter behind a password checker: opens on a correct submit, locks out after MAX_FAIL
// consecutive wrong submits. Define ALARM_BLINK_EN to blink alarm_led during lockout.
module password_attempt_ctrl #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pass_ok,
  input  logic       pass_err,
  input  logic       submit,
  output logic       unlock_led,
  output logic       alarm_led,
  output logic       locked,
  output logic [2:0] fail_cnt
);

  localparam int TMR_W = $clog2(LOCK_CYCLES);
  localparam logic [2:0] MAX_CNT = 3'(MAX_FAIL);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN, LOCKED} state_t;

  state_t           state;
  logic             submit_q;
  logic [TMR_W-1:0] timer;
  logic             attempt;
  logic             good;

`ifdef ALARM_BLINK_EN
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
  logic [BLK_W-1:0] blink_cnt;
`endif

  // Rising edge of the key only; submit_q resets high so a key held through reset is not an attempt.
  assign attempt = submit & ~submit_q;
  // Both indications high (or both low) is treated as a failure.
  assign good    = pass_ok & ~pass_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      submit_q   <= 1'b1;
      fail_cnt   <= 3'd0;
      timer      <= '0;
      unlock_led <= 1'b0;
      alarm_led  <= 1'b0;
      locked     <= 1'b0;
`ifdef ALARM_BLINK_EN
      blink_cnt  <= '0;
`endif
    end else begin
      submit_q <= submit;
      case (state)
        IDLE: begin
          if (en && attempt) begin
            if (good) begin
              state      <= OPEN;
              unlock_led <= 1'b1;
              fail_cnt   <= 3'd0;
            end else if (fail_cnt + 3'd1 == MAX_CNT) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              alarm_led <= 1'b1;
              timer     <= TMR_LOAD;
              fail_cnt  <= MAX_CNT;
`ifdef ALARM_BLINK_EN
              blink_cnt <= '0;
`endif
            end else begin
              fail_cnt <= fail_cnt + 3'd1;
            end
          end
        end
        OPEN: begin
          if (!en) begin
            state      <= IDLE;
            unlock_led <= 1'b0;
          end
        end
        LOCKED: begin
          // Timer loaded with LOCK_CYCLES-1 so the exit edge lands exactly LOCK_CYCLES after entry.
          if (timer == '0) begin
            state     <= IDLE;
            locked    <= 1'b0;
            alarm_led <= 1'b0;
            fail_cnt  <= 3'd0;
          end else begin
            timer <= timer - TMR_W'(1);
`ifdef ALARM_BLINK_EN
            if (blink_cnt == BLK_LAST) begin
              blink_cnt <= '0;
              alarm_led <= ~alarm_led;
            end else begin
              blink_cnt <= blink_cnt + BLK_W'(1);
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
